vga_bar_display: RTL

Parametrised VGA timing generator and renderer for the tug-of-war game board: it draws a row of `NUM_LEDS` boxes, two "ready" side bars and a background in up to `COLOR_W` bits per channel. It replaces the fixed 7-LED, 1-bit-colour display driver. It sits between the game FSM, which supplies LED pattern, ready flags and colours, and the VGA connector pins. All game inputs are sampled once per frame into shadow registers, so the picture never tears. An optional blink mode flashes the LED row.

---
 rtl/vga_bar_display.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/vga_bar_display.sv
// vga_bar_display: VGA timing generator and tug-of-war board renderer
//
// Draws a row of NUM_LEDS boxes, two "ready" side bars and a background.
// Every game input is captured into a shadow register once per frame, on
// the last clock of the last active line, so a frame never mixes two
// input states.
//
// Ports:
//   clk25        pixel clock
//   rst_n        asynchronous active-low reset
//   fg_rgb       foreground colour {R,G,B}, COLOR_W bits per channel
//   bg_rgb       background colour {R,G,B}
//   show_ready   enables the ready bars
//   ready_l      left player ready
//   ready_r      right player ready
//   leds_in      LED pattern, bit NUM_LEDS-1 is the leftmost box
//   blink_req    flash the LED row (only with VGA_BLINK_EN)
//   rgb          pixel colour, zero during blanking
//   hsync        horizontal sync, active low
//   vsync        vertical sync, active low
//   de           active-video flag
//   frame_start  one-cycle pulse aligned with pixel (0,0) on rgb
//
// Build option: define VGA_BLINK_EN to flash the LED row with a half-period
// of BLINK_FRAMES frames while blink_req is set.
module vga_bar_display #(
    parameter int NUM_LEDS     = 7,
    parameter int COLOR_W      = 1,
    parameter int H_ACTIVE     = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_ACTIVE     = 480,
    parameter int V_FP         = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 33,
    parameter int LED_X0       = 15,
    parameter int LED_W        = 71,
    parameter int LED_PITCH    = 90,
    parameter int LED_Y0       = 159,
    parameter int LED_Y1       = 319,
    parameter int READY_W      = 10,
    parameter int BLINK_FRAMES = 16
) (
    input  logic                   clk25,
    input  logic                   rst_n,
    input  logic [3*COLOR_W-1:0]   fg_rgb,
    input  logic [3*COLOR_W-1:0]   bg_rgb,
    input  logic                   show_ready,
    input  logic                   ready_l,
    input  logic                   ready_r,
    input  logic [NUM_LEDS-1:0]    leds_in,
    input  logic                   blink_req,
    output logic [3*COLOR_W-1:0]   rgb,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   de,
    output logic                   frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int CW      = 3 * COLOR_W;

    logic [HW-1:0]       hcnt_q, hcnt_d;
    logic [VW-1:0]       vcnt_q, vcnt_d;
    logic                h_last, v_last, capture;
    int                  h, v;

    logic [CW-1:0]       fg_q, fg_d, bg_q, bg_d;
    logic [NUM_LEDS-1:0] leds_q, leds_d;
    logic                show_ready_q, show_ready_d;
    logic                ready_l_q, ready_l_d;
    logic                ready_r_q, ready_r_d;

    logic                led_mute, led_hit, bar_hit, active;
    logic [CW-1:0]       rgb_q, rgb_d;
    logic                de_q, de_d;
    logic                hsync_q, hsync_d;
    logic                vsync_q, vsync_d;
    logic                frame_start_q, frame_start_d;

    assign h_last  = hcnt_q == HW'(H_TOTAL - 1);
    assign v_last  = vcnt_q == VW'(V_TOTAL - 1);
    // Last clock of the last active line: the whole picture has been sent.
    assign capture = h_last && vcnt_q == VW'(V_ACTIVE - 1);
    assign h       = int'(hcnt_q);
    assign v       = int'(vcnt_q);

    always_comb begin
        hcnt_d = h_last ? '0 : hcnt_q + 1'b1;
        vcnt_d = !h_last ? vcnt_q : (v_last ? '0 : vcnt_q + 1'b1);
    end

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
        end
    end

    always_comb begin
        fg_d         = capture ? fg_rgb     : fg_q;
        bg_d         = capture ? bg_rgb     : bg_q;
        leds_d       = capture ? leds_in    : leds_q;
        show_ready_d = capture ? show_ready : show_ready_q;
        ready_l_d    = capture ? ready_l    : ready_l_q;
        ready_r_d    = capture ? ready_r    : ready_r_q;
    end

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            fg_q         <= '0;
            bg_q         <= '0;
            leds_q       <= '0;
            show_ready_q <= 1'b0;
            ready_l_q    <= 1'b0;
            ready_r_q    <= 1'b0;
        end else begin
            fg_q         <= fg_d;
            bg_q         <= bg_d;
            leds_q       <= leds_d;
            show_ready_q <= show_ready_d;
            ready_l_q    <= ready_l_d;
            ready_r_q    <= ready_r_d;
        end
    end

`ifdef VGA_BLINK_EN
    localparam int BW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;

    logic [BW-1:0] fcnt_q, fcnt_d;
    logic          fwrap;
    logic          phase_q, phase_d;
    logic          blink_req_q, blink_req_d;

    // The frame counter advances at each capture point, so the phase and
    // the blink request always change together at a frame boundary.
    assign fwrap = fcnt_q == BW'(BLINK_FRAMES - 1);

    always_comb begin
        fcnt_d      = !capture ? fcnt_q : (fwrap ? '0 : fcnt_q + 1'b1);
        phase_d     = phase_q ^ (capture && fwrap);
        blink_req_d = capture ? blink_req : blink_req_q;
    end

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            fcnt_q      <= '0;
            phase_q     <= 1'b0;
            blink_req_q <= 1'b0;
        end else begin
            fcnt_q      <= fcnt_d;
            phase_q     <= phase_d;
            blink_req_q <= blink_req_d;
        end
    end

    assign led_mute = blink_req_q && phase_q;
`else
    logic unused_blink;

    assign unused_blink = blink_req ^ (BLINK_FRAMES == 0);
    assign led_mute     = 1'b0;
`endif

    // Boxes past the right edge of the active area are removed by the
    // active-video gate below rather than by the box test itself.
    always_comb begin
        led_hit = 1'b0;
        for (int i = 0; i < NUM_LEDS; i++)
            led_hit = led_hit | (leds_q[NUM_LEDS-1-i] &&
                                 h >= LED_X0 + i * LED_PITCH &&
                                 h <  LED_X0 + i * LED_PITCH + LED_W);
        led_hit = led_hit && v >= LED_Y0 && v <= LED_Y1 && !led_mute;
    end

    always_comb begin
        bar_hit       = show_ready_q && ((ready_l_q && h < READY_W) ||
                                         (ready_r_q && h >= H_ACTIVE - READY_W));
        active        = h < H_ACTIVE && v < V_ACTIVE;
        rgb_d         = !active ? '0 : ((led_hit || bar_hit) ? fg_q : bg_q);
        de_d          = active;
        hsync_d       = !(h >= H_ACTIVE + H_FP && h < H_ACTIVE + H_FP + H_SYNC);
        vsync_d       = !(v >= V_ACTIVE + V_FP && v < V_ACTIVE + V_FP + V_SYNC);
        frame_start_d = hcnt_q == '0 && vcnt_q == '0;
    end

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q         <= '0;
            de_q          <= 1'b0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            rgb_q         <= rgb_d;
            de_q          <= de_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign rgb         = rgb_q;
    assign de          = de_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = frame_start_q;
endmodule
